// File: rtl/ahmes_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahmes_mem_pkg
// Purpose  : Shared definitions for the single-port RAM request master:
//            default address/data widths and the controller state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ahmes_mem_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_RD_ISSUE   = 2'd2,
    ST_RD_CAPTURE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_master
// Purpose  : Converts valid/ready read/write requests into cycles on a
//            single-port synchronous RAM (registered read data) and returns
//            a one-cycle response pulse per access.
// Ports    : clk, rst                       - clock, sync active-high reset
//            req_valid/req_ready/req_we/
//            req_addr/req_wdata             - request handshake
//            rsp_valid/rsp_rdata            - response pulse and read data
//            mem_wr_en/mem_address/
//            mem_data_in/mem_data_out       - RAM port
//            busy                           - controller not idle
//            req_len/rsp_last               - burst length / final beat,
//                                             present only with MEM_BURST_EN
// Config   : MEM_BURST_EN enables multi-beat reads (up to 4 beats).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_master
  import ahmes_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BURST_EN
  input  logic [1:0]        req_len,
  output logic              rsp_last,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_address;
  logic [DATA_W-1:0] w_data_in;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_rdata;
`ifdef MEM_BURST_EN
  // r_issue_left: addresses still to be issued after the current one.
  // r_cap_left  : beats still to be captured after the current one.
  logic [1:0]        r_issue_left;
  logic [1:0]        r_cap_left;
  logic [1:0]        w_issue_left;
  logic [1:0]        w_cap_left;
  logic              w_rsp_last;
`endif

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_state     = r_state;
    w_wr_en     = 1'b0;
    w_address   = mem_address;
    w_data_in   = mem_data_in;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = rsp_rdata;
`ifdef MEM_BURST_EN
    w_issue_left = r_issue_left;
    w_cap_left   = r_cap_left;
    w_rsp_last   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_address = req_addr;
          if (req_we) begin
            w_state   = ST_WRITE;
            w_wr_en   = 1'b1;
            w_data_in = req_wdata;
          end else begin
            w_state = ST_RD_ISSUE;
`ifdef MEM_BURST_EN
            w_issue_left = req_len;
            w_cap_left   = req_len;
`endif
          end
        end
      end
      ST_WRITE: begin
        w_state     = ST_IDLE;
        w_rsp_valid = 1'b1;
`ifdef MEM_BURST_EN
        w_rsp_last  = 1'b1;
`endif
      end
      ST_RD_ISSUE: begin
        // RAM samples the first address at this edge; data lands next edge.
        w_state = ST_RD_CAPTURE;
`ifdef MEM_BURST_EN
        if (r_issue_left != 2'd0) begin
          w_address    = mem_address + 1'b1;
          w_issue_left = r_issue_left - 2'd1;
        end
`endif
      end
      ST_RD_CAPTURE: begin
        w_rsp_rdata = mem_data_out;
        w_rsp_valid = 1'b1;
`ifdef MEM_BURST_EN
        // Issue and capture run one beat apart, so the pipeline streams
        // one beat per cycle with the address wrapping naturally.
        if (r_issue_left != 2'd0) begin
          w_address    = mem_address + 1'b1;
          w_issue_left = r_issue_left - 2'd1;
        end
        if (r_cap_left == 2'd0) begin
          w_state    = ST_IDLE;
          w_rsp_last = 1'b1;
        end else begin
          w_cap_left = r_cap_left - 2'd1;
        end
`else
        w_state = ST_IDLE;
`endif
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      mem_wr_en   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef MEM_BURST_EN
      r_issue_left <= 2'd0;
      r_cap_left   <= 2'd0;
      rsp_last     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      mem_wr_en   <= w_wr_en;
      mem_address <= w_address;
      mem_data_in <= w_data_in;
      rsp_valid   <= w_rsp_valid;
      rsp_rdata   <= w_rsp_rdata;
`ifdef MEM_BURST_EN
      r_issue_left <= w_issue_left;
      r_cap_left   <= w_cap_left;
      rsp_last     <= w_rsp_last;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_master
// Purpose  : Self-checking bench for mem_port_master with a behavioural RAM
//            and an array-based reference of the memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
`ifdef MEM_BURST_EN
  logic [1:0] req_len;
  logic       rsp_last;
`endif
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  logic [7:0] last_rdata;

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_address] <= mem_data_in;
    else           mem_data_out     <= ram[mem_address];
  end

  mem_port_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_BURST_EN
    .req_len(req_len), .rsp_last(rsp_last),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-beat access, called one step after a rising edge while idle.
  task automatic do_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
`ifdef MEM_BURST_EN
    req_len = we ? 2'($urandom) : 2'd0;
`endif
    chk("ready_before", req_ready, 1);
    step();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom);
    chk("busy_accept", busy, 1);
    chk("addr_issue", mem_address, a);
    chk("wr_en_issue", mem_wr_en, we);
    chk("rsp_early", rsp_valid, 0);
    if (we) begin
      chk("wdata_issue", mem_data_in, d);
      step();
      model_mem[a] = d;
      chk("wr_ack", rsp_valid, 1);
      chk("wr_en_drop", mem_wr_en, 0);
      chk("ready_ack", req_ready, 1);
      chk("rdata_hold", rsp_rdata, last_rdata);
`ifdef MEM_BURST_EN
      chk("last_wr", rsp_last, 1);
`endif
    end else begin
      step();
      chk("rd_mid_valid", rsp_valid, 0);
      chk("rd_mid_busy", busy, 1);
      chk("rd_mid_addr", mem_address, a);
      step();
      chk("rd_ack", rsp_valid, 1);
      chk("rd_data", rsp_rdata, model_mem[a]);
      chk("rd_wr_en", mem_wr_en, 0);
      last_rdata = model_mem[a];
`ifdef MEM_BURST_EN
      chk("last_rd", rsp_last, 1);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef MEM_BURST_EN
    req_len = 2'd0;
`endif
    last_rdata = 8'h00;
    step(); step();
    rst = 1'b0;
    // Reset state
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_data_in, 0);
    chk("rst_rdata", rsp_rdata, 0);

    // Preload every location with random data through the DUT.
    for (int i = 0; i < 256; i++) do_access(1'b1, 8'(i), 8'($urandom));

    // Write 0x5A to 0x10 then read it straight back.
    do_access(1'b1, 8'h10, 8'h5A);
    do_access(1'b0, 8'h10, 8'h00);
    chk("wr_rd_5a", rsp_rdata, 8'h5A);

    // Write 0x00 to 0x80 over nonzero contents, then read immediately.
    do_access(1'b1, 8'h80, 8'hC3);
    do_access(1'b1, 8'h80, 8'h00);
    do_access(1'b0, 8'h80, 8'hFF);
    chk("wr_rd_zero", rsp_rdata, 8'h00);

    // Back-to-back reads of 0x00 and 0xFF with req_valid held.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
    step();
    req_addr = 8'hFF;
    chk("b2b_addr0", mem_address, 8'h00);
    chk("b2b_wr0", mem_wr_en, 0);
    step();
    chk("b2b_hold", mem_address, 8'h00);
    chk("b2b_wr1", mem_wr_en, 0);
    step();
    chk("b2b_v0", rsp_valid, 1);
    chk("b2b_d0", rsp_rdata, model_mem[8'h00]);
    chk("b2b_rdy", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("b2b_addr1", mem_address, 8'hFF);
    chk("b2b_busy1", busy, 1);
    chk("b2b_wr2", mem_wr_en, 0);
    step();
    chk("b2b_wr3", mem_wr_en, 0);
    step();
    chk("b2b_v1", rsp_valid, 1);
    chk("b2b_d1", rsp_rdata, model_mem[8'hFF]);
    last_rdata = model_mem[8'hFF];

    // Idle with toggling request fields: nothing must happen.
    for (int i = 0; i < 6; i++) begin
      req_we = 1'(i); req_addr = 8'($urandom);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_wr_en", mem_wr_en, 0);
      chk("idle_rsp", rsp_valid, 0);
    end

    // Reset coincident with a write request: the write never reaches RAM.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = ~model_mem[8'h33];
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b0;
    chk("rstk_wr_en", mem_wr_en, 0);
    chk("rstk_busy", busy, 0);
    last_rdata = 8'h00;
    do_access(1'b0, 8'h33, 8'h00);

    // Reset at the edge after a write is accepted: no acknowledge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h44; req_wdata = 8'hA5;
    step();
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst1_valid", rsp_valid, 0);
    chk("rst1_wr_en", mem_wr_en, 0);
    chk("rst1_ready", req_ready, 1);
    chk("rst1_rdata", rsp_rdata, 0);
    step();
    chk("rst1_valid2", rsp_valid, 0);
    last_rdata = 8'h00;
    do_access(1'b1, 8'h44, 8'h96);
    do_access(1'b0, 8'h44, 8'h00);

    // Random mixed traffic.
    for (int i = 0; i < 60; i++) do_access(1'($urandom), 8'($urandom), 8'($urandom));

`ifdef MEM_BURST_EN
    // Burst read of 4 beats wrapping from 0xFE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 2'd3;
    step();
    req_valid = 1'b0;
    chk("bst_a0", mem_address, 8'hFE);
    step();
    chk("bst_a1", mem_address, 8'hFF);
    chk("bst_nv", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea;
      step();
      ea = 8'hFE + 8'(i);
      chk("bst_valid", rsp_valid, 1);
      chk("bst_data", rsp_rdata, model_mem[ea]);
      chk("bst_last", rsp_last, (i == 3) ? 1 : 0);
      chk("bst_ready", req_ready, (i == 3) ? 1 : 0);
      last_rdata = model_mem[ea];
    end
    step();
    chk("bst_end", rsp_valid, 0);
    do_access(1'b1, 8'h01, 8'h7E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, memory address width; DATA_W, default 8, memory data width.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_W  request address.
REQ-008 req_wdata  input  DATA_W  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: read data valid, or write complete.
REQ-010 rsp_rdata  output  DATA_W  read data; holds its last value otherwise.
REQ-011 mem_wr_en  output  1  drives the RAM write enable.
REQ-012 mem_address  output  ADDR_W  drives the RAM address.
REQ-013 mem_data_in  output  DATA_W  drives the RAM write data.
REQ-014 mem_data_out  input  DATA_W  RAM read data; registered, valid one edge after the address is sampled while write enable is low.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 A request SHALL be accepted on an edge where req_valid and req_ready are both high; request inputs SHALL be ignored otherwise.
REQ-017 req_ready SHALL equal (state == IDLE); all outputs to the RAM SHALL be registered.
REQ-018 FSM states SHALL be IDLE, WRITE, RD_ISSUE and RD_CAPTURE.
REQ-019 On accepting a write at edge k, the FSM SHALL enter WRITE.
- mem_wr_en SHALL be 1 for exactly the cycle after edge k, with mem_address = req_addr and mem_data_in = req_wdata.
- The FSM SHALL return to IDLE at edge k+1.
- rsp_valid SHALL be 1 for the cycle after edge k+1.
REQ-020 On accepting a read at edge k, the FSM SHALL drive mem_address = req_addr with mem_wr_en = 0 and sequence as follows:
- RD_ISSUE at k+1.
- RD_CAPTURE after k+1.
- At edge k+2, rsp_rdata SHALL take mem_data_out and the FSM SHALL return to IDLE.
- rsp_valid SHALL be 1 for the cycle after edge k+2.
REQ-021 The rsp_valid cycle SHALL coincide with IDLE, so back-to-back requests are accepted during it: write throughput one per 2 cycles, read one per 3.
REQ-022 mem_wr_en SHALL be 0 in every cycle except the single WRITE cycle, and SHALL never be 1 for two consecutive cycles.
REQ-023 mem_address and mem_data_in SHALL hold their last values while in IDLE.
REQ-024 A write followed immediately by a read of the same address SHALL return the newly written data.

Reset
REQ-025 While rst = 1 at an edge, the block SHALL set:
- state = IDLE, req_ready = 1 in the next cycle;
- rsp_valid = 0, mem_wr_en = 0, busy = 0;
- mem_address = 0, mem_data_in = 0, rsp_rdata = 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no rsp_valid pulse; an aborted write SHALL not reach the RAM if rst is sampled at edge k.

Configuration
REQ-027 With MEM_BURST_EN defined, the block SHALL add the ports req_len (input, 2 bits, beats-1) and rsp_last (output, 1 bit, final beat).
REQ-028 Under MEM_BURST_EN, a burst read SHALL behave as follows:
- It SHALL issue addresses req_addr + i (i = 0..req_len) on consecutive cycles, wrapping modulo 2**ADDR_W (0xFF -> 0x00).
- It SHALL produce one rsp_valid beat per cycle, with the first beat at the same latency as a single read.
- rsp_last SHALL be 1 on the final beat only.
REQ-029 Under MEM_BURST_EN, writes SHALL ignore req_len and be single-beat, with rsp_last = 1 on the write acknowledge.
REQ-030 Without MEM_BURST_EN, req_len and rsp_last SHALL be absent and all accesses SHALL be single-beat.

Structure
REQ-031 The package ahmes_mem_pkg SHALL hold the ADDR_W/DATA_W defaults and the FSM state enum type.
REQ-032 No sub-module SHALL be used; the burst counter SHALL be inline logic in mem_port_master.

Verification
REQ-033 Write 0x5A to 0x10, then read 0x10 -> mem_wr_en pulses 1 cycle with address 0x10; rsp_valid after 2 cycles with rsp_rdata = 0x5A at 3 cycles after read acceptance.
REQ-034 Back-to-back reads of 0x00 and 0xFF with req_valid held -> second accepted in the first rsp_valid cycle; rdata values in order; no cycle with mem_wr_en = 1.
REQ-035 Reset asserted at the edge after a write is accepted -> no rsp_valid; mem_wr_en = 0; req_ready = 1 in the following cycle.
REQ-036 req_valid = 0 with a toggling req_we/req_addr -> no RAM activity; busy stays 0.
REQ-037 MEM_BURST_EN, read at 0xFE with req_len = 3 -> 4 consecutive rsp_valid beats from 0xFE, 0xFF, 0x00, 0x01; rsp_last on the 4th beat only.
REQ-038 Write 0x00 to 0x80, read 0x80 in the next accepted cycle -> rsp_rdata = 0x00; the prior contents are not returned.
